// File: rtl/uart_rx_packet_ctrl.sv
//==============================================================================
// Module      : uart_rx_packet_ctrl
// Description : Frames UART receiver bytes into checksummed packets
//               (SYNC, LEN, payload, CSUM). The payload is buffered and only
//               released on a valid/ready stream once the checksum matches.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_packet_ctrl #(
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 208_333
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_flag_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o,
    output logic       pkt_ok_o,
    output logic       pkt_err_o,
    output logic [1:0] err_code_o,
    output logic       rx_drop_o,
    output logic       busy_o
);

    localparam int         IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TMO     = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             flag_q;
    logic [7:0]       len_q, len_d;
    logic [7:0]       csum_q, csum_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [TO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             pkt_ok_q, pkt_ok_d;
    logic             pkt_err_q, pkt_err_d;
    logic             rx_drop_q, rx_drop_d;
    logic             buf_we;
    logic [7:0]       buf_q [MAX_LEN];

    // Rising edge of the receiver's level done flag marks one new byte.
    logic byte_evt;
    logic wr_last;
    logic rd_last;
    logic in_drain;

    assign byte_evt = rx_flag_i & ~flag_q;
    assign wr_last  = (8'(wr_idx_q) == (len_q - 8'd1));
    assign rd_last  = (8'(rd_idx_q) == (len_q - 8'd1));
    assign in_drain = (state_q == S_DRAIN);

    // State and bookkeeping registers; flag_q resets high so a flag already
    // asserted when reset releases is not mistaken for a fresh byte.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_HUNT;
            flag_q     <= 1'b1;
            len_q      <= '0;
            csum_q     <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            tmo_q      <= '0;
            err_code_q <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            rx_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flag_q     <= rx_flag_i;
            len_q      <= len_d;
            csum_q     <= csum_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            tmo_q      <= tmo_d;
            err_code_q <= err_code_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_err_q  <= pkt_err_d;
            rx_drop_q  <= rx_drop_d;
        end
    end

    // Payload buffer write port; contents need no reset since len gates reads.
    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            buf_q[wr_idx_q] <= rx_data_i;
        end
    end

    // Packet sequencing, checksum accumulation, inter-byte timeout and drain.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        tmo_d      = tmo_q;
        err_code_d = err_code_q;
        pkt_ok_d   = 1'b0;
        pkt_err_d  = 1'b0;
        rx_drop_d  = 1'b0;
        buf_we     = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (byte_evt && (rx_data_i == SYNC_BYTE)) begin
                    state_d = S_LEN;
                    tmo_d   = '0;
                end
            end
            S_LEN: begin
                if (byte_evt) begin
                    tmo_d = '0;
                    if ((rx_data_i != 8'd0) && (rx_data_i <= MAX_LEN_B)) begin
                        len_d    = rx_data_i;
                        csum_d   = rx_data_i;
                        wr_idx_d = '0;
                        state_d  = S_PAYLOAD;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = S_HUNT;
                    end
                end else if (tmo_q == TO_LAST) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = S_HUNT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (byte_evt) begin
                    tmo_d    = '0;
                    buf_we   = 1'b1;
                    csum_d   = csum_q + rx_data_i;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_last) begin
                        state_d = S_CSUM;
                    end
                end else if (tmo_q == TO_LAST) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = S_HUNT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CSUM: begin
                if (byte_evt) begin
                    tmo_d = '0;
                    if (rx_data_i == csum_q) begin
                        pkt_ok_d = 1'b1;
                        rd_idx_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_CSUM;
                        state_d    = S_HUNT;
                    end
                end else if (tmo_q == TO_LAST) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = S_HUNT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Bytes arriving while draining are dropped, SYNC included.
                if (byte_evt) begin
                    rx_drop_d = 1'b1;
                end
                if (out_ready_i) begin
                    if (rd_last) begin
                        state_d = S_HUNT;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    assign out_valid_o = in_drain;
    assign out_data_o  = in_drain ? buf_q[rd_idx_q] : 8'd0;
    assign out_last_o  = in_drain & rd_last;
    assign pkt_ok_o    = pkt_ok_q;
    assign pkt_err_o   = pkt_err_q;
    assign err_code_o  = err_code_q;
    assign rx_drop_o   = rx_drop_q;
    assign busy_o      = (state_q != S_HUNT);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_packet_ctrl.sv
//==============================================================================
// Module      : tb_uart_rx_packet_ctrl
// Description : Directed self-checking bench for uart_rx_packet_ctrl
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx_packet_ctrl;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_flag = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       rx_drop;
    logic       busy;

    uart_rx_packet_ctrl #(
        .MAX_LEN     (16),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .rx_data_i   (rx_data),
        .rx_flag_i   (rx_flag),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last),
        .pkt_ok_o    (pkt_ok),
        .pkt_err_o   (pkt_err),
        .err_code_o  (err_code),
        .rx_drop_o   (rx_drop),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Event counters and accepted-byte log, sampled on the falling edge.
    int         n_ok = 0, n_perr = 0, n_drop = 0, n_valid = 0, n_viol = 0;
    logic [7:0] cap_q[$];
    logic       last_q[$];
    logic       stalled = 1'b0;
    logic [7:0] st_data = 8'h00;
    logic       st_last = 1'b0;

    always @(negedge clk) begin
        if (pkt_ok)    n_ok    <= n_ok + 1;
        if (pkt_err)   n_perr  <= n_perr + 1;
        if (rx_drop)   n_drop  <= n_drop + 1;
        if (out_valid) n_valid <= n_valid + 1;
        if (out_valid && out_ready) begin
            cap_q.push_back(out_data);
            last_q.push_back(out_last);
        end
        if (stalled && out_valid && ((out_data != st_data) || (out_last != st_last)))
            n_viol <= n_viol + 1;
        stalled <= out_valid && !out_ready;
        st_data <= out_data;
        st_last <= out_last;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_flag = 1'b1;
        cyc(2);
        rx_flag = 1'b0;
        cyc(1);
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    function automatic logic [7:0] cap_at(input int idx);
        return (idx < cap_q.size()) ? cap_q[idx] : 8'hxx;
    endfunction

    function automatic logic last_at(input int idx);
        return (idx < last_q.size()) ? last_q[idx] : 1'bx;
    endfunction

    task automatic test_reset;
        reset = 1'b1; rx_flag = 1'b1; rx_data = 8'hA5;
        cyc(3);
        n_vec++; if ({out_valid, out_last, pkt_ok, pkt_err, rx_drop, busy} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl: got %b required 000000", {out_valid, out_last, pkt_ok, pkt_err, rx_drop, busy}); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h required 00", out_data); end
        n_vec++; if (err_code !== 2'd0) begin n_err++; $display("FAIL reset_errcode: got %0d required 0", err_code); end
        reset = 1'b0;
        cyc(3);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_flag_high: busy got %b required 0", busy); end
        rx_flag = 1'b0;
        cyc(2);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_flag_drop: busy got %b required 0", busy); end
    endtask

    task automatic test_good_packet;
        int ok0 = n_ok, er0 = n_perr, base = cap_q.size();
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        bit idle;
        out_ready = 1'b1;
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
        wait_idle(idle);
        cyc(2);
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL good_idle: drain did not finish"); end
        n_vec++; if (n_ok - ok0 !== 1) begin n_err++; $display("FAIL good_pkt_ok: got %0d required 1", n_ok - ok0); end
        n_vec++; if (n_perr - er0 !== 0) begin n_err++; $display("FAIL good_pkt_err: got %0d required 0", n_perr - er0); end
        n_vec++; if (cap_q.size() - base !== 3) begin n_err++; $display("FAIL good_count: got %0d required 3", cap_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (cap_at(base + i) !== exp[i]) begin n_err++; $display("FAIL good_data[%0d]: got %h required %h", i, cap_at(base + i), exp[i]); end
            n_vec++; if (last_at(base + i) !== (i == 2)) begin n_err++; $display("FAIL good_last[%0d]: got %b required %b", i, last_at(base + i), (i == 2)); end
        end
    endtask

    task automatic test_bad_csum;
        int er0 = n_perr, ok0 = n_ok, v0 = n_valid;
        out_ready = 1'b1;
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A});
        cyc(3);
        n_vec++; if (n_perr - er0 !== 1) begin n_err++; $display("FAIL csum_pkt_err: got %0d required 1", n_perr - er0); end
        n_vec++; if (n_ok - ok0 !== 0) begin n_err++; $display("FAIL csum_pkt_ok: got %0d required 0", n_ok - ok0); end
        n_vec++; if (err_code !== 2'd2) begin n_err++; $display("FAIL csum_errcode: got %0d required 2", err_code); end
        n_vec++; if (n_valid - v0 !== 0) begin n_err++; $display("FAIL csum_valid: got %0d valid cycles required 0", n_valid - v0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL csum_busy: got %b required 0", busy); end
    endtask

    task automatic test_bad_len;
        int er0 = n_perr, ok0, base;
        out_ready = 1'b1;
        send_seq('{8'hA5, 8'h00});
        cyc(2);
        n_vec++; if (n_perr - er0 !== 1) begin n_err++; $display("FAIL len0_pkt_err: got %0d required 1", n_perr - er0); end
        n_vec++; if (err_code !== 2'd1) begin n_err++; $display("FAIL len0_errcode: got %0d required 1", err_code); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL len0_busy: got %b required 0", busy); end
        er0 = n_perr;
        send_seq('{8'hA5, 8'h11});
        cyc(2);
        n_vec++; if (n_perr - er0 !== 1) begin n_err++; $display("FAIL len17_pkt_err: got %0d required 1", n_perr - er0); end
        n_vec++; if (err_code !== 2'd1) begin n_err++; $display("FAIL len17_errcode: got %0d required 1", err_code); end
        ok0 = n_ok; base = cap_q.size();
        send_seq('{8'hA5, 8'h01, 8'h07, 8'h08});
        cyc(4);
        n_vec++; if (n_ok - ok0 !== 1) begin n_err++; $display("FAIL len_recover_ok: got %0d required 1", n_ok - ok0); end
        n_vec++; if (cap_at(base) !== 8'h07) begin n_err++; $display("FAIL len_recover_data: got %h required 07", cap_at(base)); end
        n_vec++; if (err_code !== 2'd1) begin n_err++; $display("FAIL errcode_sticky: got %0d required 1", err_code); end
    endtask

    task automatic test_max_len;
        // 16 payload bytes F0..FF plus LEN 10: sum 3976 wraps to 88
        int ok0 = n_ok, base = cap_q.size();
        logic [7:0] q[$];
        bit idle;
        out_ready = 1'b1;
        q.push_back(8'hA5);
        q.push_back(8'h10);
        for (int i = 0; i < 16; i++) q.push_back(8'hF0 + 8'(i));
        q.push_back(8'h88);
        send_seq(q);
        wait_idle(idle);
        cyc(2);
        n_vec++; if (n_ok - ok0 !== 1) begin n_err++; $display("FAIL max_pkt_ok: got %0d required 1", n_ok - ok0); end
        n_vec++; if (cap_q.size() - base !== 16) begin n_err++; $display("FAIL max_count: got %0d required 16", cap_q.size() - base); end
        for (int i = 0; i < 16; i++) begin
            n_vec++; if (cap_at(base + i) !== 8'hF0 + 8'(i)) begin n_err++; $display("FAIL max_data[%0d]: got %h required %h", i, cap_at(base + i), 8'hF0 + 8'(i)); end
        end
        n_vec++; if (last_at(base + 15) !== 1'b1 || last_at(base + 14) !== 1'b0) begin n_err++; $display("FAIL max_last: got %b%b required 01", last_at(base + 14), last_at(base + 15)); end
    endtask

    task automatic test_timeout;
        int er0 = n_perr, ok0, base;
        out_ready = 1'b1;
        send_seq('{8'hA5, 8'h02, 8'h10});
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL tmo_busy_before: got %b required 1", busy); end
        cyc(TMO + 10);
        n_vec++; if (n_perr - er0 !== 1) begin n_err++; $display("FAIL tmo_pkt_err: got %0d required 1", n_perr - er0); end
        n_vec++; if (err_code !== 2'd3) begin n_err++; $display("FAIL tmo_errcode: got %0d required 3", err_code); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_busy_after: got %b required 0", busy); end
        // Gaps just under the limit must not expire
        er0 = n_perr; ok0 = n_ok; base = cap_q.size();
        send_seq('{8'hA5, 8'h01});
        cyc(30);
        send_byte(8'h05);
        cyc(30);
        send_byte(8'h06);
        cyc(4);
        n_vec++; if (n_ok - ok0 !== 1 || n_perr - er0 !== 0) begin n_err++; $display("FAIL tmo_slow_pkt: ok %0d err %0d required 1 0", n_ok - ok0, n_perr - er0); end
        n_vec++; if (cap_at(base) !== 8'h05) begin n_err++; $display("FAIL tmo_slow_data: got %h required 05", cap_at(base)); end
    endtask

    task automatic test_drain_stall;
        // LEN 03 + AA + BB + CC = 564 -> 34
        int ok0 = n_ok, dr0 = n_drop, vi0 = n_viol, base = cap_q.size();
        logic [7:0] exp [3] = '{8'hAA, 8'hBB, 8'hCC};
        bit idle;
        out_ready = 1'b0;
        send_seq('{8'hA5, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h34});
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hAA || out_last !== 1'b0) begin n_err++; $display("FAIL stall_first: got v%b d%h l%b required v1 dAA l0", out_valid, out_data, out_last); end
        out_ready = 1'b1; cyc(1);
        out_ready = 1'b0; cyc(1);
        n_vec++; if (out_data !== 8'hBB) begin n_err++; $display("FAIL stall_hold1: got %h required BB", out_data); end
        cyc(1);
        n_vec++; if (out_data !== 8'hBB) begin n_err++; $display("FAIL stall_hold2: got %h required BB", out_data); end
        out_ready = 1'b1; cyc(1);
        out_ready = 1'b0;
        send_byte(8'hA5);
        n_vec++; if (out_data !== 8'hCC || out_last !== 1'b1) begin n_err++; $display("FAIL stall_last: got d%h l%b required dCC l1", out_data, out_last); end
        out_ready = 1'b1;
        wait_idle(idle);
        cyc(3);
        n_vec++; if (idle !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL stall_idle: busy %b required 0", busy); end
        n_vec++; if (n_drop - dr0 !== 1) begin n_err++; $display("FAIL stall_rx_drop: got %0d required 1", n_drop - dr0); end
        n_vec++; if (n_viol - vi0 !== 0) begin n_err++; $display("FAIL stall_stability: got %0d changes required 0", n_viol - vi0); end
        n_vec++; if (n_ok - ok0 !== 1) begin n_err++; $display("FAIL stall_pkt_ok: got %0d required 1", n_ok - ok0); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (cap_at(base + i) !== exp[i]) begin n_err++; $display("FAIL stall_data[%0d]: got %h required %h", i, cap_at(base + i), exp[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int ok0 = n_ok, er0 = n_perr, dr0 = n_drop, base;
        out_ready = 1'b1;
        send_seq('{8'hA5, 8'h04, 8'h01, 8'h02});
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b required 1", busy); end
        reset = 1'b1;
        cyc(2);
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || err_code !== 2'd0) begin n_err++; $display("FAIL mid_reset_out: busy %b valid %b err %0d required 0 0 0", busy, out_valid, err_code); end
        reset = 1'b0;
        cyc(1);
        send_seq('{8'h00, 8'hFF});
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL garbage_busy: got %b required 0", busy); end
        base = cap_q.size();
        send_seq('{8'hA5, 8'h01, 8'h07, 8'h08});
        cyc(4);
        n_vec++; if (n_ok - ok0 !== 1 || n_perr - er0 !== 0 || n_drop - dr0 !== 0) begin n_err++; $display("FAIL mid_pulses: ok %0d err %0d drop %0d required 1 0 0", n_ok - ok0, n_perr - er0, n_drop - dr0); end
        n_vec++; if (cap_at(base) !== 8'h07) begin n_err++; $display("FAIL mid_recover_data: got %h required 07", cap_at(base)); end
        n_vec++; if (err_code !== 2'd0) begin n_err++; $display("FAIL mid_errcode: got %0d required 0", err_code); end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_csum();
        test_bad_len();
        test_max_len();
        test_timeout();
        test_drain_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
